rob_retire_unit: RTL

Consumer end of the completion interface. Holds a 64-entry circular reorder buffer allocated in program order by dispatch. It accepts up to three completion reports per cycle (ROB index, dest reg, data, PC) from the complete stage and marks the matching entries done. It retires up to two done entries per cycle in order from the head, driving the regfile/free-list commit ports.

---
 rtl/rob_pkg.sv | 38 +++
 rtl/rob_retire_select.sv | 27 ++
 rtl/rob_retire_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared constants and types for the reorder buffer retire unit.
package rob_pkg;

    localparam int unsigned ROB_DEPTH = 64;
    localparam int unsigned IDX_W     = $clog2(ROB_DEPTH);
    localparam int unsigned PREG_W    = 6;
    localparam int unsigned XLEN      = 32;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dr;
        logic [XLEN-1:0]   pc;
        logic [PREG_W-1:0] dr;
        logic [PREG_W-1:0] old_dr;
        logic [XLEN-1:0]   data;
    } rob_entry_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [PREG_W-1:0] dr;
        logic [PREG_W-1:0] old_dr;
        logic [XLEN-1:0]   data;
    } retire_slot_t;

    // Register fields are zeroed for entries that never wrote a register.
    function automatic retire_slot_t to_slot(rob_entry_t e);
        retire_slot_t s;
        s.valid  = 1'b1;
        s.pc     = e.pc;
        s.dr     = e.has_dr ? e.dr : '0;
        s.old_dr = e.has_dr ? e.old_dr : '0;
        s.data   = e.data;
        return s;
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Combinational in-order readiness check of the two oldest ROB entries.
module rob_retire_select
    import rob_pkg::*;
(
    input  logic [IDX_W-1:0]     head,
    input  logic [ROB_DEPTH-1:0] valid,
    input  logic [ROB_DEPTH-1:0] done,
    output logic [1:0]           retire_cnt,
    output logic [IDX_W-1:0]     idx0,
    output logic [IDX_W-1:0]     idx1
);

    logic rdy0;
    logic rdy1;

    always_comb begin
        idx0       = head;
        idx1       = head + IDX_W'(1);
        rdy0       = valid[idx0] & done[idx0];
        rdy1       = valid[idx1] & done[idx1];
        retire_cnt = 2'd0;
        if (rdy0) begin
            retire_cnt = rdy1 ? 2'd2 : 2'd1;
        end
    end

endmodule

// File: rtl/rob_retire_unit.sv
// 64-entry reorder buffer: in-order alloc, 3-wide completion, 2-wide in-order retire.
// Optional ROB_PC_CHECK_EN adds a sticky cmpl_err output for bad completion reports.
module rob_retire_unit
    import rob_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [XLEN-1:0]   alloc_pc,
    input  logic [PREG_W-1:0] alloc_dr,
    input  logic [PREG_W-1:0] alloc_old_dr,
    input  logic              alloc_has_dr,
    output logic [IDX_W-1:0]  alloc_rob_idx,
    input  logic              complete_valid_0,
    input  logic [IDX_W-1:0]  ROB_complete_0,
    input  logic [PREG_W-1:0] complete_dr_0,
    input  logic [XLEN-1:0]   new_dr_data_0,
    input  logic [XLEN-1:0]   complete_pc_0,
    input  logic              complete_valid_1,
    input  logic [IDX_W-1:0]  ROB_complete_1,
    input  logic [PREG_W-1:0] complete_dr_1,
    input  logic [XLEN-1:0]   new_dr_data_1,
    input  logic [XLEN-1:0]   complete_pc_1,
    input  logic              complete_valid_2,
    input  logic [IDX_W-1:0]  ROB_complete_2,
    input  logic [PREG_W-1:0] complete_dr_2,
    input  logic [XLEN-1:0]   new_dr_data_2,
    input  logic [XLEN-1:0]   complete_pc_2,
    output logic              retire_valid_0,
    output logic [XLEN-1:0]   retire_pc_0,
    output logic [PREG_W-1:0] retire_dr_0,
    output logic [PREG_W-1:0] retire_old_dr_0,
    output logic [XLEN-1:0]   retire_data_0,
    output logic              retire_valid_1,
    output logic [XLEN-1:0]   retire_pc_1,
    output logic [PREG_W-1:0] retire_dr_1,
    output logic [PREG_W-1:0] retire_old_dr_1,
    output logic [XLEN-1:0]   retire_data_1,
    output logic [IDX_W:0]    rob_count,
    output logic              rob_empty
`ifdef ROB_PC_CHECK_EN
    ,
    output logic              cmpl_err
`endif
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_DEPTH);

    rob_entry_t       rob_q [ROB_DEPTH];
    rob_entry_t       rob_d [ROB_DEPTH];
    retire_slot_t     ret_q [2];
    retire_slot_t     ret_d [2];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;

    logic [ROB_DEPTH-1:0] valid_vec;
    logic [ROB_DEPTH-1:0] done_vec;
    logic [1:0]           retire_cnt;
    logic [IDX_W-1:0]     ret_idx0;
    logic [IDX_W-1:0]     ret_idx1;
    logic                 alloc_fire;

    logic             cv    [3];
    logic [IDX_W-1:0] cidx  [3];
    logic [XLEN-1:0]  cdata [3];

    assign cv[0]    = complete_valid_0;
    assign cv[1]    = complete_valid_1;
    assign cv[2]    = complete_valid_2;
    assign cidx[0]  = ROB_complete_0;
    assign cidx[1]  = ROB_complete_1;
    assign cidx[2]  = ROB_complete_2;
    assign cdata[0] = new_dr_data_0;
    assign cdata[1] = new_dr_data_1;
    assign cdata[2] = new_dr_data_2;

    // Completion dest regs are already known from allocation.
    logic unused_dr;
    assign unused_dr = ^{complete_dr_0, complete_dr_1, complete_dr_2};

    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            valid_vec[i] = rob_q[i].valid;
            done_vec[i]  = rob_q[i].done;
        end
    end

    rob_retire_select u_select (
        .head       (head_q),
        .valid      (valid_vec),
        .done       (done_vec),
        .retire_cnt (retire_cnt),
        .idx0       (ret_idx0),
        .idx1       (ret_idx1)
    );

    assign alloc_ready   = (count_q != FULL_CNT);
    assign alloc_fire    = alloc_valid & alloc_ready;
    assign alloc_rob_idx = tail_q;
    assign rob_count     = count_q;
    assign rob_empty     = (count_q == '0);

    always_comb begin
        rob_d    = rob_q;
        ret_d[0] = '0;
        ret_d[1] = '0;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Later ports overwrite earlier ones targeting the same index.
            for (int p = 0; p < 3; p++) begin
                if (cv[p] && rob_q[cidx[p]].valid) begin
                    rob_d[cidx[p]].done = 1'b1;
                    rob_d[cidx[p]].data = cdata[p];
                end
            end
            if (retire_cnt != 2'd0) begin
                ret_d[0]              = to_slot(rob_q[ret_idx0]);
                rob_d[ret_idx0].valid = 1'b0;
                rob_d[ret_idx0].done  = 1'b0;
            end
            if (retire_cnt == 2'd2) begin
                ret_d[1]              = to_slot(rob_q[ret_idx1]);
                rob_d[ret_idx1].valid = 1'b0;
                rob_d[ret_idx1].done  = 1'b0;
            end
            head_d = head_q + IDX_W'(retire_cnt);
            if (alloc_fire) begin
                rob_d[tail_q]        = '0;
                rob_d[tail_q].valid  = 1'b1;
                rob_d[tail_q].has_dr = alloc_has_dr;
                rob_d[tail_q].pc     = alloc_pc;
                rob_d[tail_q].dr     = alloc_dr;
                rob_d[tail_q].old_dr = alloc_old_dr;
                tail_d               = tail_q + IDX_W'(1);
            end
            count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(retire_cnt);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            ret_q[0] <= '0;
            ret_q[1] <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            rob_q    <= rob_d;
            ret_q[0] <= ret_d[0];
            ret_q[1] <= ret_d[1];
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    assign retire_valid_0  = ret_q[0].valid;
    assign retire_pc_0     = ret_q[0].pc;
    assign retire_dr_0     = ret_q[0].dr;
    assign retire_old_dr_0 = ret_q[0].old_dr;
    assign retire_data_0   = ret_q[0].data;
    assign retire_valid_1  = ret_q[1].valid;
    assign retire_pc_1     = ret_q[1].pc;
    assign retire_dr_1     = ret_q[1].dr;
    assign retire_old_dr_1 = ret_q[1].old_dr;
    assign retire_data_1   = ret_q[1].data;

`ifdef ROB_PC_CHECK_EN
    logic            cmpl_err_q, cmpl_err_d;
    logic            err_hit;
    logic [XLEN-1:0] cpc [3];

    assign cpc[0] = complete_pc_0;
    assign cpc[1] = complete_pc_1;
    assign cpc[2] = complete_pc_2;

    always_comb begin
        err_hit = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (cv[p] && (!rob_q[cidx[p]].valid || rob_q[cidx[p]].pc != cpc[p])) begin
                err_hit = 1'b1;
            end
        end
        cmpl_err_d = flush ? 1'b0 : (cmpl_err_q | err_hit);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmpl_err_q <= 1'b0;
        end else begin
            cmpl_err_q <= cmpl_err_d;
        end
    end

    assign cmpl_err = cmpl_err_q;
`else
    logic unused_pc;
    assign unused_pc = ^{complete_pc_0, complete_pc_1, complete_pc_2};
`endif

endmodule
